// File: rtl/im_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state encoding,
// default memory geometry and state-class helpers.
package im_boot_loader_pkg;

  localparam int IM_DEPTH_DEFAULT = 64;
  localparam int IM_AW            = $clog2(IM_DEPTH_DEFAULT << 2);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    CHKSUM,
    DONE,
    ERROR
  } boot_state_t;

  // States in which a byte may be taken from the stream.
  function automatic logic is_rx_state(input boot_state_t s);
    return s inside {LEN_LO, LEN_HI, DATA, CHKSUM};
  endfunction

  // States that belong to a load in progress.
  function automatic logic is_busy(input boot_state_t s);
    return !(s inside {IDLE, DONE, ERROR});
  endfunction

endpackage

// File: rtl/im_boot_loader_timeout.sv
// Load-clear idle watchdog: counts enabled cycles and flags the cycle in which
// the count would reach LIMIT. Reusable for any byte-stream loader.
module boot_timeout_ctr #(
  parameter int LIMIT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // The increment on this edge would make LIMIT idle cycles.
  assign expired = enable && !clear && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/im_boot_loader.sv
// Framed byte-stream loader feeding the instruction-memory write port.
// Define IM_BOOT_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module im_boot_loader
  import im_boot_loader_pkg::*;
#(
  parameter int IM_DEPTH       = IM_DEPTH_DEFAULT,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                              clk_100MHz,
  input  logic                              reset,
  input  logic                              start,
  input  logic [7:0]                        rx_data,
  input  logic                              rx_valid,
  output logic                              rx_ready,
  output logic [$clog2(IM_DEPTH<<2)-1:0]    writeAddr_IM,
  output logic [31:0]                       writeData_IM,
  output logic                              writeEn_IM,
  output logic                              Memory_Initialization,
  output logic                              load_done,
  output logic                              load_error,
  output logic [$clog2(IM_DEPTH):0]         words_loaded
);

  localparam int AW = $clog2(IM_DEPTH << 2);
  localparam logic [15:0] DEPTH16 = 16'(IM_DEPTH);

  boot_state_t state, next_state;

  logic [15:0] len;
  logic [23:0] word_lo;
  logic [1:0]  byte_idx;
  logic        accept;
  logic        begin_load;
  logic        timeout;
  logic [15:0] len_full;
  logic        len_bad;
  logic        last_word;
`ifdef IM_BOOT_CHECKSUM_EN
  logic [7:0]  chk;
`endif

  assign rx_ready  = is_rx_state(state);
  assign accept    = rx_valid && rx_ready;
  assign len_full  = {rx_data, len[7:0]};
  assign len_bad   = (len_full == 16'd0) || (len_full > DEPTH16);
  assign last_word = (16'(words_loaded + 1'b1) == len);

  boot_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk_100MHz),
    .rst_n   (reset),
    .clear   (accept || !is_rx_state(state)),
    .enable  (is_rx_state(state)),
    .expired (timeout)
  );

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    begin_load = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          next_state = LEN_LO;
          begin_load = 1'b1;
        end
      end
      LEN_LO: begin
        if (accept)       next_state = LEN_HI;
        else if (timeout) next_state = ERROR;
      end
      LEN_HI: begin
        if (accept)       next_state = len_bad ? ERROR : DATA;
        else if (timeout) next_state = ERROR;
      end
      DATA: begin
        if (accept) begin
          if (byte_idx == 2'd3) next_state = WRITE;
        end else if (timeout) begin
          next_state = ERROR;
        end
      end
      WRITE: begin
`ifdef IM_BOOT_CHECKSUM_EN
        next_state = last_word ? CHKSUM : DATA;
`else
        next_state = last_word ? DONE : DATA;
`endif
      end
`ifdef IM_BOOT_CHECKSUM_EN
      CHKSUM: begin
        if (accept)       next_state = (rx_data == chk) ? DONE : ERROR;
        else if (timeout) next_state = ERROR;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      len                   <= '0;
      word_lo               <= '0;
      byte_idx              <= '0;
      words_loaded          <= '0;
      writeEn_IM            <= 1'b0;
      writeAddr_IM          <= '0;
      writeData_IM          <= '0;
      Memory_Initialization <= 1'b0;
      load_done             <= 1'b0;
      load_error            <= 1'b0;
`ifdef IM_BOOT_CHECKSUM_EN
      chk                   <= '0;
`endif
    end else begin
      // The write port is only non-zero for the single WRITE cycle.
      writeEn_IM            <= 1'b0;
      writeAddr_IM          <= '0;
      writeData_IM          <= '0;
      Memory_Initialization <= is_busy(next_state);

      if (begin_load) begin
        len          <= '0;
        byte_idx     <= '0;
        words_loaded <= '0;
        load_done    <= 1'b0;
        load_error   <= 1'b0;
`ifdef IM_BOOT_CHECKSUM_EN
        chk          <= '0;
`endif
      end

      if (state != DONE && next_state == DONE)   load_done  <= 1'b1;
      if (state != ERROR && next_state == ERROR) load_error <= 1'b1;

      case (state)
        LEN_LO: if (accept) len[7:0]  <= rx_data;
        LEN_HI: if (accept) len[15:8] <= rx_data;
        DATA: begin
          if (accept) begin
`ifdef IM_BOOT_CHECKSUM_EN
            chk <= chk ^ rx_data;
`endif
            byte_idx <= byte_idx + 1'b1;
            case (byte_idx)
              2'd0: word_lo[7:0]   <= rx_data;
              2'd1: word_lo[15:8]  <= rx_data;
              2'd2: word_lo[23:16] <= rx_data;
              default: begin
                writeEn_IM   <= 1'b1;
                writeAddr_IM <= {words_loaded[AW-3:0], 2'b00};
                writeData_IM <= {rx_data, word_lo};
              end
            endcase
          end
        end
        WRITE: words_loaded <= words_loaded + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
